// File: rtl/spi_write_arbiter.sv
// spi_write_arbiter
//
// Shares one single-port framebuffer RAM between the SPI write stream and the
// display scanout read port. SPI writes are queued in a small FIFO. Scanout
// reads win arbitration. While writes are waiting, consecutive read grants are
// limited to MAX_READ_BURST, so a queued write issues within MAX_READ_BURST+1
// cycles.
//
// Optional feature macro: SPI_WRITE_ARBITER_DROP_COUNT_EN
//   When defined, adds output drop_count[15:0]. It is a saturating count of
//   dropped write strobes.
//
// Ports:
//   clk, rst       system clock, synchronous active-high reset
//   wr_strobe      one-cycle pulse: new write (wr_address / wr_data)
//   rd_req         scanout read request, held until rd_grant
//   rd_address     scanout read address
//   rd_grant       read issued to RAM this cycle (combinational)
//   rd_valid       rd_data valid, one cycle after rd_grant (registered)
//   rd_data        read data (RAM output while rd_valid, else 0)
//   ram_address    RAM address, ram_wdata / ram_we write port (combinational)
//   ram_rdata      RAM read data, valid the cycle after the address
//   fifo_level     number of queued writes
//   overflow       sticky flag: a write was dropped
//   drop_count     saturating dropped-write count (macro only)
module spi_write_arbiter #(
    parameter int ADDRESS_BUS_WIDTH = 16,
    parameter int DATA_BUS_WIDTH    = 16,
    parameter int FIFO_DEPTH        = 4,
    parameter int MAX_READ_BURST    = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                wr_strobe,
    input  logic [ADDRESS_BUS_WIDTH-1:0]        wr_address,
    input  logic [DATA_BUS_WIDTH-1:0]           wr_data,
    input  logic                                rd_req,
    input  logic [ADDRESS_BUS_WIDTH-1:0]        rd_address,
    output logic                                rd_grant,
    output logic                                rd_valid,
    output logic [DATA_BUS_WIDTH-1:0]           rd_data,
    output logic [ADDRESS_BUS_WIDTH-1:0]        ram_address,
    output logic [DATA_BUS_WIDTH-1:0]           ram_wdata,
    output logic                                ram_we,
    input  logic [DATA_BUS_WIDTH-1:0]           ram_rdata,
    output logic [$clog2(FIFO_DEPTH):0]         fifo_level,
`ifdef SPI_WRITE_ARBITER_DROP_COUNT_EN
    output logic [15:0]                         drop_count,
`endif
    output logic                                overflow
);

    localparam int IDX_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = IDX_W + 1;
    localparam int RUN_W = $clog2(MAX_READ_BURST + 1);
    localparam int ENT_W = ADDRESS_BUS_WIDTH + DATA_BUS_WIDTH;

    localparam logic [LVL_W-1:0] LEVEL_FULL = LVL_W'(FIFO_DEPTH);
    localparam logic [RUN_W-1:0] RUN_MAX    = RUN_W'(MAX_READ_BURST);

    typedef enum logic [1:0] {
        SLOT_IDLE,
        SLOT_READ,
        SLOT_WRITE
    } slot_t;

    // Queue storage holds data only, so it has no reset.
    logic [ENT_W-1:0] fifo_mem [FIFO_DEPTH];

    // Pointers carry one extra bit so that full and empty can be told apart.
    logic [LVL_W-1:0] wr_ptr;
    logic [LVL_W-1:0] rd_ptr;
    logic [RUN_W-1:0] read_run;
    logic             rd_valid_q;
    logic             overflow_q;

    slot_t            slot;
    logic             fifo_empty;
    logic             fifo_full;
    logic             pop;
    logic             push;
    logic             drop;
    logic [ENT_W-1:0] head;

    assign fifo_level = wr_ptr - rd_ptr;
    assign fifo_empty = (fifo_level == '0);
    assign fifo_full  = (fifo_level == LEVEL_FULL);
    assign head       = fifo_mem[rd_ptr[IDX_W-1:0]];

    // Slot decision. Reads win unless writes are waiting and the read run has
    // used up its budget.
    always_comb begin
        slot = SLOT_IDLE;
        if (rst) begin
            slot = SLOT_IDLE;
        end else if (rd_req && (fifo_empty || (read_run < RUN_MAX))) begin
            slot = SLOT_READ;
        end else if (!fifo_empty) begin
            slot = SLOT_WRITE;
        end
    end

    // A full queue still accepts a strobe when the head leaves in the same cycle.
    assign pop  = (slot == SLOT_WRITE);
    assign push = !rst && wr_strobe && (!fifo_full || pop);
    assign drop = !rst && wr_strobe && fifo_full && !pop;

    always_comb begin
        rd_grant    = (slot == SLOT_READ);
        ram_we      = (slot == SLOT_WRITE);
        ram_wdata   = head[DATA_BUS_WIDTH-1:0];
        ram_address = head[ENT_W-1:DATA_BUS_WIDTH];
        if (slot == SLOT_READ) begin
            ram_address = rd_address;
        end
    end

    // The RAM registers its output, so read data appears together with rd_valid.
    assign rd_data  = rd_valid_q ? ram_rdata : '0;
    assign rd_valid = rd_valid_q;
    assign overflow = overflow_q;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[IDX_W-1:0]] <= {wr_address, wr_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            read_run   <= '0;
            rd_valid_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            rd_valid_q <= (slot == SLOT_READ);
            if (drop) begin
                overflow_q <= 1'b1;
            end
            // The read budget only runs while writes are waiting.
            if (fifo_empty || (slot == SLOT_WRITE)) begin
                read_run <= '0;
            end else if ((slot == SLOT_READ) && (read_run < RUN_MAX)) begin
                read_run <= read_run + 1'b1;
            end
        end
    end

`ifdef SPI_WRITE_ARBITER_DROP_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_count <= '0;
        end else if (drop && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_spi_write_arbiter.sv
module tb_spi_write_arbiter;

    logic        clk;
    logic        rst;
    logic        wr_strobe;
    logic [15:0] wr_address;
    logic [15:0] wr_data;
    logic        rd_req;
    logic [15:0] rd_address;
    logic        rd_grant;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic [15:0] ram_address;
    logic [15:0] ram_wdata;
    logic        ram_we;
    logic [15:0] ram_rdata;
    logic [2:0]  fifo_level;
    logic        overflow;
`ifdef SPI_WRITE_ARBITER_DROP_COUNT_EN
    logic [15:0] drop_count;
`endif

    int checks = 0;
    int errors = 0;

    spi_write_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .wr_strobe  (wr_strobe),
        .wr_address (wr_address),
        .wr_data    (wr_data),
        .rd_req     (rd_req),
        .rd_address (rd_address),
        .rd_grant   (rd_grant),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .ram_address(ram_address),
        .ram_wdata  (ram_wdata),
        .ram_we     (ram_we),
        .ram_rdata  (ram_rdata),
        .fifo_level (fifo_level),
`ifdef SPI_WRITE_ARBITER_DROP_COUNT_EN
        .drop_count (drop_count),
`endif
        .overflow   (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous RAM model with a registered read port and a write log.
    logic [15:0] ram [0:65535];
    logic [15:0] wlog_a[$];
    logic [15:0] wlog_d[$];

    always @(posedge clk) begin
        ram_rdata <= ram[ram_address];
        if (ram_we) begin
            ram[ram_address] <= ram_wdata;
            wlog_a.push_back(ram_address);
            wlog_d.push_back(ram_wdata);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    // Inputs change 1 time unit after the rising edge; outputs are sampled mid-cycle.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid_cycle();
        #4;
    endtask

    task automatic do_reset();
        next_cycle();
        rst = 1'b1;
        wr_strobe = 1'b0;
        rd_req = 1'b0;
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rd_req = 1'b1;
        rd_address = 16'h0001;
        wr_strobe = 1'b0;
        wr_address = 16'h0;
        wr_data = 16'h0;
        next_cycle();
        mid_cycle();
        checks++;
        if (rd_grant !== 1'b0) begin errors++; $display("FAIL reset_grant: got %b expected 0", rd_grant); end
        checks++;
        if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", ram_we); end
        next_cycle();
        rst = 1'b0;
        rd_req = 1'b0;
        mid_cycle();
        checks++;
        if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        checks++;
        if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
        checks++;
        if (rd_data !== 16'h0) begin errors++; $display("FAIL reset_rd_data: got %h expected 0000", rd_data); end
`ifdef SPI_WRITE_ARBITER_DROP_COUNT_EN
        checks++;
        if (drop_count !== 16'd0) begin errors++; $display("FAIL reset_drop_count: got %0d expected 0", drop_count); end
`endif
    endtask

    task automatic test_single_write();
        next_cycle();
        wr_strobe = 1'b1;
        wr_address = 16'h0010;
        wr_data = 16'hBEEF;
        rd_req = 1'b0;
        mid_cycle();
        checks++;
        if (ram_we !== 1'b0) begin errors++; $display("FAIL write_latency: got ram_we %b expected 0", ram_we); end
        next_cycle();
        wr_strobe = 1'b0;
        mid_cycle();
        checks++;
        if (ram_we !== 1'b1) begin errors++; $display("FAIL write_we: got %b expected 1", ram_we); end
        checks++;
        if (ram_address !== 16'h0010) begin errors++; $display("FAIL write_addr: got %h expected 0010", ram_address); end
        checks++;
        if (ram_wdata !== 16'hBEEF) begin errors++; $display("FAIL write_data: got %h expected beef", ram_wdata); end
        checks++;
        if (fifo_level !== 3'd1) begin errors++; $display("FAIL write_level_q: got %0d expected 1", fifo_level); end
        next_cycle();
        mid_cycle();
        checks++;
        if (fifo_level !== 3'd0) begin errors++; $display("FAIL write_level_empty: got %0d expected 0", fifo_level); end
        checks++;
        if (ram_we !== 1'b0) begin errors++; $display("FAIL write_we_after: got %b expected 0", ram_we); end
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL write_overflow: got %b expected 0", overflow); end
        checks++;
        if (ram[16'h0010] !== 16'hBEEF) begin errors++; $display("FAIL write_ram: got %h expected beef", ram[16'h0010]); end
    endtask

    task automatic test_read_stream();
        // Seed RAM location 0x0100 with 0x1234 through the write path.
        next_cycle();
        wr_strobe = 1'b1;
        wr_address = 16'h0100;
        wr_data = 16'h1234;
        next_cycle();
        wr_strobe = 1'b0;
        next_cycle();
        next_cycle();
        for (int i = 0; i < 8; i++) begin
            if (i > 0) next_cycle();
            rd_req = (i < 6);
            rd_address = 16'h0100;
            mid_cycle();
            if (i < 6) begin
                checks++;
                if (rd_grant !== 1'b1) begin errors++; $display("FAIL read_grant[%0d]: got %b expected 1", i, rd_grant); end
                checks++;
                if (ram_we !== 1'b0) begin errors++; $display("FAIL read_we[%0d]: got %b expected 0", i, ram_we); end
                checks++;
                if (ram_address !== 16'h0100) begin errors++; $display("FAIL read_addr[%0d]: got %h expected 0100", i, ram_address); end
            end else begin
                checks++;
                if (rd_grant !== 1'b0) begin errors++; $display("FAIL read_grant_off[%0d]: got %b expected 0", i, rd_grant); end
            end
            checks++;
            if (rd_valid !== ((i >= 1) && (i <= 6))) begin errors++; $display("FAIL read_valid[%0d]: got %b expected %b", i, rd_valid, ((i >= 1) && (i <= 6))); end
            if ((i >= 1) && (i <= 6)) begin
                checks++;
                if (rd_data !== 16'h1234) begin errors++; $display("FAIL read_data[%0d]: got %h expected 1234", i, rd_data); end
            end
        end
    endtask

    task automatic test_burst_limit();
        int granted_while_queued;
        granted_while_queued = 0;
        for (int i = 0; i < 11; i++) begin
            next_cycle();
            rd_req = 1'b1;
            rd_address = 16'h0100;
            wr_strobe = (i == 0);
            wr_address = 16'h0020;
            wr_data = 16'h5A5A;
            mid_cycle();
            if (rd_grant && (fifo_level != 3'd0)) granted_while_queued++;
            checks++;
            if (rd_grant !== (i != 9)) begin errors++; $display("FAIL burst_grant[%0d]: got %b expected %b", i, rd_grant, (i != 9)); end
            checks++;
            if (ram_we !== (i == 9)) begin errors++; $display("FAIL burst_we[%0d]: got %b expected %b", i, ram_we, (i == 9)); end
            if (i == 9) begin
                checks++;
                if (ram_address !== 16'h0020) begin errors++; $display("FAIL burst_addr: got %h expected 0020", ram_address); end
            end
        end
        checks++;
        if (granted_while_queued !== 8) begin errors++; $display("FAIL burst_count: got %0d expected 8", granted_while_queued); end
        next_cycle();
        rd_req = 1'b0;
        wr_strobe = 1'b0;
        mid_cycle();
        checks++;
        if (ram[16'h0020] !== 16'h5A5A) begin errors++; $display("FAIL burst_ram: got %h expected 5a5a", ram[16'h0020]); end
    endtask

    task automatic test_overflow();
        int base;
        base = wlog_a.size();
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            rd_req = 1'b1;
            wr_strobe = 1'b1;
            wr_address = 16'h0030 + 16'(i);
            wr_data = 16'hA000 + 16'(i);
            mid_cycle();
            if (i == 4) begin
                checks++;
                if (fifo_level !== 3'd4) begin errors++; $display("FAIL ovf_level_full: got %0d expected 4", fifo_level); end
                checks++;
                if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b expected 0", overflow); end
            end
            if (i == 5) begin
                checks++;
                if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", overflow); end
                checks++;
                if (fifo_level !== 3'd4) begin errors++; $display("FAIL ovf_level_hold: got %0d expected 4", fifo_level); end
            end
        end
        next_cycle();
        wr_strobe = 1'b0;
        rd_req = 1'b0;
        for (int i = 0; i < 6; i++) next_cycle();
        mid_cycle();
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
        checks++;
        if (fifo_level !== 3'd0) begin errors++; $display("FAIL ovf_drained: got %0d expected 0", fifo_level); end
`ifdef SPI_WRITE_ARBITER_DROP_COUNT_EN
        checks++;
        if (drop_count !== 16'd2) begin errors++; $display("FAIL ovf_drop_count: got %0d expected 2", drop_count); end
`endif
        checks++;
        if (wlog_a.size() - base !== 4) begin
            errors++; $display("FAIL ovf_write_count: got %0d expected 4", wlog_a.size() - base);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if ((wlog_a[base+i] !== 16'h0030 + 16'(i)) || (wlog_d[base+i] !== 16'hA000 + 16'(i)))
                begin
                    errors++;
                    $display("FAIL ovf_order[%0d]: got %h/%h expected %h/%h", i, wlog_a[base+i], wlog_d[base+i],
                             16'h0030 + 16'(i), 16'hA000 + 16'(i));
                end
            end
        end
    endtask

    task automatic test_full_push_pop();
        int  base;
        bit  found;
        do_reset();
        base = wlog_a.size();
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) next_cycle();
            rd_req = 1'b1;
            rd_address = 16'h0100;
            wr_strobe = 1'b1;
            wr_address = 16'h0040 + 16'(i);
            wr_data = 16'hC000 + 16'(i);
        end
        for (int i = 0; i < 20; i++) begin
            next_cycle();
            wr_strobe = 1'b0;
            mid_cycle();
            if (ram_we) begin
                found = 1'b1;
                checks++;
                if (fifo_level !== 3'd4) begin errors++; $display("FAIL pp_level_before: got %0d expected 4", fifo_level); end
                wr_strobe = 1'b1;
                wr_address = 16'h0044;
                wr_data = 16'hC004;
                break;
            end
        end
        checks++;
        if (!found) begin errors++; $display("FAIL pp_no_write: got none expected ram_we within 20 cycles"); end
        next_cycle();
        wr_strobe = 1'b0;
        rd_req = 1'b0;
        mid_cycle();
        checks++;
        if (fifo_level !== 3'd4) begin errors++; $display("FAIL pp_level_after: got %0d expected 4", fifo_level); end
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL pp_overflow: got %b expected 0", overflow); end
        for (int i = 0; i < 6; i++) next_cycle();
        mid_cycle();
        checks++;
        if (wlog_a.size() - base !== 5) begin
            errors++; $display("FAIL pp_write_count: got %0d expected 5", wlog_a.size() - base);
        end else begin
            checks++;
            if (wlog_a[base] !== 16'h0040) begin errors++; $display("FAIL pp_first: got %h expected 0040", wlog_a[base]); end
            checks++;
            if ((wlog_a[base+4] !== 16'h0044) || (wlog_d[base+4] !== 16'hC004)) begin
                errors++; $display("FAIL pp_last: got %h/%h expected 0044/c004", wlog_a[base+4], wlog_d[base+4]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int base;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            rd_req = 1'b1;
            rd_address = 16'h0100;
            wr_strobe = 1'b1;
            wr_address = 16'h0050 + 16'(i);
            wr_data = 16'hD000 + 16'(i);
        end
        next_cycle();
        wr_strobe = 1'b0;
        mid_cycle();
        checks++;
        if (fifo_level !== 3'd3) begin errors++; $display("FAIL rm_level3: got %0d expected 3", fifo_level); end
        checks++;
        if (rd_grant !== 1'b1) begin errors++; $display("FAIL rm_grant: got %b expected 1", rd_grant); end
        next_cycle();
        rst = 1'b1;
        rd_req = 1'b0;
        mid_cycle();
        checks++;
        if ((rd_grant !== 1'b0) || (ram_we !== 1'b0)) begin
            errors++; $display("FAIL rm_in_reset: got grant %b we %b expected 0 0", rd_grant, ram_we);
        end
        next_cycle();
        rst = 1'b0;
        mid_cycle();
        base = wlog_a.size();
        checks++;
        if (fifo_level !== 3'd0) begin errors++; $display("FAIL rm_level: got %0d expected 0", fifo_level); end
        checks++;
        if (rd_valid !== 1'b0) begin errors++; $display("FAIL rm_rd_valid: got %b expected 0", rd_valid); end
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            mid_cycle();
            checks++;
            if (ram_we !== 1'b0) begin errors++; $display("FAIL rm_no_we[%0d]: got %b expected 0", i, ram_we); end
        end
        checks++;
        if (wlog_a.size() !== base) begin errors++; $display("FAIL rm_log: got %0d writes expected 0", wlog_a.size() - base); end
        next_cycle();
        wr_strobe = 1'b1;
        wr_address = 16'h0060;
        wr_data = 16'hE001;
        next_cycle();
        wr_strobe = 1'b0;
        mid_cycle();
        checks++;
        if ((ram_we !== 1'b1) || (ram_address !== 16'h0060)) begin
            errors++; $display("FAIL rm_new_write: got we %b addr %h expected 1 0060", ram_we, ram_address);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read_stream();
        test_burst_limit();
        test_overflow();
        test_full_push_pop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_write_arbiter.md
Name: spi_write_arbiter

Overview:
- Shares one single-port framebuffer RAM between two masters: the SPI write stream (address/data/write_strobe from the SPI receiver) and a display scanout read port.
- SPI writes are queued in a small FIFO. Scanout reads have priority, with a bounded burst so queued writes are never starved.
- Sits between the SPI receiver, the scanout engine and the RAM, entirely in the system clock domain.

Parameters:
ADDRESS_BUS_WIDTH, 16, width of RAM word address
DATA_BUS_WIDTH, 16, width of RAM data word
FIFO_DEPTH, 4, write queue entries; power of two, >= 2
MAX_READ_BURST, 8, max consecutive read grants while the write FIFO is non-empty; >= 1

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
wr_strobe  input  1  one-cycle pulse: new write (from SPI receiver write_strobe)
wr_address  input  ADDRESS_BUS_WIDTH  write address, valid with wr_strobe
wr_data  input  DATA_BUS_WIDTH  write data, valid with wr_strobe
rd_req  input  1  scanout read request, held until granted
rd_address  input  ADDRESS_BUS_WIDTH  read address, stable while rd_req high
rd_grant  output  1  combinational: read issued to RAM this cycle
rd_valid  output  1  registered: rd_data valid (one cycle after rd_grant)
rd_data  output  DATA_BUS_WIDTH  read data
ram_address  output  ADDRESS_BUS_WIDTH  RAM address (combinational)
ram_wdata  output  DATA_BUS_WIDTH  RAM write data (combinational)
ram_we  output  1  RAM write enable (combinational)
ram_rdata  input  DATA_BUS_WIDTH  RAM read data, registered inside RAM, valid the cycle after the address
fifo_level  output  clogb2(FIFO_DEPTH)+1  current queued-write count
overflow  output  1  sticky: a write was dropped

Behaviour:
- Reset (rst high at a clk edge):
  - FIFO emptied; fifo_level=0; overflow=0; rd_valid=0; rd_data=0; read_run counter=0.
  - During the reset cycle: rd_grant=0 and ram_we=0.
  - Reset mid-operation discards queued writes; an in-flight read's rd_valid is suppressed.
- Arbitration, evaluated each cycle (not in reset):
  - READ slot if rd_req && (fifo_level==0 || read_run < MAX_READ_BURST).
  - Else WRITE slot if fifo_level != 0.
  - Else IDLE.
- READ slot:
  - rd_grant=1, ram_address=rd_address, ram_we=0.
  - Next cycle: rd_valid=1, rd_data=ram_rdata (captured the same cycle).
- WRITE slot:
  - ram_address/ram_wdata = FIFO head; ram_we=1; head popped at the clock edge.
- IDLE slot:
  - ram_we=0; ram_address holds the FIFO head address (don't-care to the RAM).
- read_run counter:
  - Increments on each READ slot taken while fifo_level!=0, saturating at MAX_READ_BURST.
  - Clears to 0 on any WRITE slot, and on any cycle with fifo_level==0.
  - Guarantee: a queued write issues within MAX_READ_BURST+1 cycles.
- FIFO push (wr_strobe):
  - Accepted if fifo_level<FIFO_DEPTH, or if fifo is full and a pop occurs the same cycle.
  - Otherwise the write is dropped and overflow sets (stays 1 until rst).
  - Simultaneous push and pop: level unchanged, data order preserved.
  - Minimum write latency: strobe at cycle N -> ram_we at cycle N+1 at the earliest.
- Pointers: wrap modulo FIFO_DEPTH.
  - fifo_level=wr_ptr-rd_ptr with one extra bit; full = level==FIFO_DEPTH.
- Ordering: writes reach RAM in strobe order.
  - A read of an address with a pending queued write returns the old RAM value; no forwarding.
- rd_valid: asserts exactly once per rd_grant, never otherwise.

Optional Feature:
- Macro: SPI_WRITE_ARBITER_DROP_COUNT_EN.
- With it defined:
  - Adds output drop_count [15:0], reset 0.
  - Increments once per dropped wr_strobe, saturating at 16'hFFFF.
  - overflow behaviour unchanged.
- Without it:
  - Port and counter absent; only the sticky overflow flag reports drops.

Test Plan:
- Reset, then a single wr_strobe with addr=0x0010, data=0xBEEF and rd_req=0 -> next cycle ram_we=1, ram_address=0x0010, ram_wdata=0xBEEF; fifo_level returns to 0; overflow=0.
- rd_req held high with rd_address=0x0100, RAM model returning 0x1234 -> rd_grant every cycle; rd_valid=1 with rd_data=0x1234 one cycle after each grant; ram_we never set.
- rd_req held high continuously while one write is queued, MAX_READ_BURST=8 -> exactly 8 consecutive rd_grant, then one cycle with rd_grant=0 and ram_we=1, then grants resume.
- rd_req held high, 6 strobes back-to-back (FIFO_DEPTH=4) -> first 4 queued, fifo_level=4, 5th and 6th dropped; overflow=1 and stays 1; drop_count=2 when the macro is enabled; the 4 accepted writes reach RAM in order.
- FIFO full, and on the cycle a write is popped a wr_strobe arrives -> strobe accepted, fifo_level stays 4, overflow stays 0.
- Assert rst while fifo_level=3 and a read is in flight -> next cycle fifo_level=0, rd_valid=0, no ram_we until a new strobe arrives.
